piso_serializer: RTL and testbench
==================================

# piso_serializer

Parallel-in, serial-out transmitter: accepts a WIDTH-bit word through a valid/ready handshake and shifts it out one bit per clock on a registered serial line. It forms the transmit end of the team's serial shift-register links and feeds a serial-in shift register on the receiving side. Framing strobes mark the first and last bit of each word. Back-to-back words stream with no idle cycles.

## Interface
- WIDTH, 8, word width in bits; legal range ≥ 2
- MSB_FIRST, 1, 1 = bit WIDTH-1 is sent first; 0 = bit 0 is sent first
- clk  input  1  clock, all logic on rising edge
- rst  input  1  reset: rst, synchronous, active-high; clock clk
- din  input  WIDTH  parallel word, sampled when din_valid && din_ready
- din_valid  input  1  upstream has a word on din
- din_ready  output  1  block accepts a word this cycle (combinational)
- dout  output  1  serial data bit (registered)
- dout_valid  output  1  dout carries a valid bit (registered)
- dout_first  output  1  dout is bit 0 of the word's transmit order (registered)
- dout_last  output  1  dout is the final bit of the word (registered)
- busy  output  1  high while a word is being shifted out (= dout_valid)

## Operation
- State machine: IDLE, SHIFT.
- Internal: WIDTH-bit shift register sreg; bit counter cnt, width $clog2(WIDTH), counts 0..WIDTH-1.
- din_ready = (state == IDLE) || (state == SHIFT && cnt == WIDTH-1).
- Accept = din_valid && din_ready. On accept: sreg loads din, cnt clears to 0, state becomes SHIFT, and the first bit appears on dout at the same edge.
- In SHIFT with cnt < WIDTH-1: cnt increments; sreg shifts by one toward the output end (left when MSB_FIRST=1, right when MSB_FIRST=0, with zero fill); dout takes the next bit.
- In SHIFT with cnt == WIDTH-1 (the last bit is on dout):
  - Accept: reload, cnt = 0, stay in SHIFT. The first bit of the new word follows the last bit of the old word with no gap.
  - No accept: go to IDLE. dout_valid, dout_first, dout_last and dout all clear at that edge.
- In IDLE, dout = 0 and all strobes = 0.
- dout_first = 1 exactly when cnt == 0 in SHIFT. dout_last = 1 exactly when cnt == WIDTH-1 in SHIFT.
- din_valid while din_ready = 0 is ignored. Upstream must hold din and din_valid until accepted. The block never samples din outside an accept.
- Reset (any time, including mid-word): state IDLE; sreg, cnt, dout, dout_valid, dout_first, dout_last, busy all 0; din_ready = 1 in the cycle after reset.
  - A partially sent word is discarded.
  - din_valid during rst is not accepted.
  - rst has priority over accept.

## Timing
- Load latency: a word accepted at edge N puts its first bit on dout from edge N until edge N+1.
- Each word occupies exactly WIDTH consecutive valid cycles.
- Throughput: one word per WIDTH cycles when din_valid is held high. dout_valid stays continuously 1.
- din_ready is 1 during the last-bit cycle. This is what enables gapless streaming.
- din_ready has a combinational path from state/cnt only, with no path from din_valid, so there is no combinational loop.
- After the last bit with no new word: dout_valid = 0 one cycle later.

## Test plan
- Reset: assert rst 2 cycles with din_valid=1, din=8'hFF -> dout, dout_valid, dout_first, dout_last = 0 throughout; din_ready = 1 after release; no bits emitted.
- Single word, MSB_FIRST=1: din=8'hA5 accepted at edge N -> dout = 1,0,1,0,0,1,0,1 on cycles N..N+7; dout_first only on N; dout_last only on N+7; dout_valid = 0 at N+8.
- Back-to-back: 8'hA5 then 8'h3C with din_valid held -> 16 contiguous valid bits 10100101 00111100; dout_first at bits 0 and 8; dout_last at bits 7 and 15; din_ready high only on the two last-bit cycles and the initial idle cycle.
- LSB-first (MSB_FIRST=0): din=8'h01 -> dout = 1,0,0,0,0,0,0,0; din=8'h80 -> seven 0s then 1.
- Backpressure: present 8'h3C while 8'hA5 is mid-shift (cnt=2) -> 8'h3C is not taken until the 8'hA5 last-bit cycle; the 8'hA5 bit stream is unaltered.
- Reset mid-word: rst after 3 bits of 8'hA5 -> dout_valid = 0 next cycle; then 8'h0F is sent cleanly as 0,0,0,0,1,1,1,1 with dout_first on its first bit.

Source files
------------

// File: rtl/piso_serializer.sv
// Parallel-in, serial-out transmitter with valid/ready load and framing strobes.
// Words stream back-to-back with no idle cycles when upstream keeps din_valid high.
module piso_serializer #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             dout,
    output logic             dout_valid,
    output logic             dout_first,
    output logic             dout_last,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t           state;
    logic [WIDTH-1:0] sreg;
    logic [CW-1:0]    cnt;
    logic [CW-1:0]    cnt_inc;
    logic [WIDTH-1:0] shifted;
    logic             accept;

    function automatic logic head(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? w[WIDTH-1] : w[0];
    endfunction

    // Ready in the last-bit cycle lets the next word follow without a gap.
    assign din_ready = (state == IDLE) || (state == SHIFT && cnt == LAST);
    assign accept    = din_valid && din_ready;
    assign busy      = dout_valid;
    assign cnt_inc   = cnt + 1'b1;
    assign shifted   = MSB_FIRST ? {sreg[WIDTH-2:0], 1'b0}
                                 : {1'b0, sreg[WIDTH-1:1]};

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            sreg       <= '0;
            cnt        <= '0;
            dout       <= 1'b0;
            dout_valid <= 1'b0;
            dout_first <= 1'b0;
            dout_last  <= 1'b0;
        end else if (accept) begin
            state      <= SHIFT;
            sreg       <= din;
            cnt        <= '0;
            dout       <= head(din);
            dout_valid <= 1'b1;
            dout_first <= 1'b1;
            dout_last  <= 1'b0;
        end else if (state == SHIFT && cnt != LAST) begin
            cnt        <= cnt_inc;
            sreg       <= shifted;
            dout       <= head(shifted);
            dout_first <= 1'b0;
            dout_last  <= (cnt_inc == LAST);
        end else begin
            state      <= IDLE;
            cnt        <= '0;
            dout       <= 1'b0;
            dout_valid <= 1'b0;
            dout_first <= 1'b0;
            dout_last  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_piso_serializer.sv
// Scoreboard bench: an MSB-first and an LSB-first instance, expected bits
// queued at each accept and compared on every falling edge.
module tb_piso_serializer;

    typedef struct packed {
        logic b;
        logic first;
        logic last;
    } exp_t;

    logic       clk;
    logic       rst;
    logic [7:0] din   [2];
    logic       dv    [2];
    logic       rdy   [2];
    logic       dout  [2];
    logic       ov    [2];
    logic       first [2];
    logic       last  [2];
    logic       busy  [2];

    exp_t q [2][$];
    int   checks = 0;
    int   errors = 0;
    bit   mon_en = 0;

    piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_msb (
        .clk(clk), .rst(rst), .din(din[0]), .din_valid(dv[0]),
        .din_ready(rdy[0]), .dout(dout[0]), .dout_valid(ov[0]),
        .dout_first(first[0]), .dout_last(last[0]), .busy(busy[0])
    );

    piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_lsb (
        .clk(clk), .rst(rst), .din(din[1]), .din_valid(dv[1]),
        .din_ready(rdy[1]), .dout(dout[1]), .dout_valid(ov[1]),
        .dout_first(first[1]), .dout_last(last[1]), .busy(busy[1])
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic mon(input int i);
        exp_t e;
        if (ov[i]) begin
            if (q[i].size() == 0) begin
                chk($sformatf("spurious%0d", i), 1, 0);
            end else begin
                e = q[i].pop_front();
                chk($sformatf("dout%0d", i), dout[i], e.b);
                chk($sformatf("first%0d", i), first[i], e.first);
                chk($sformatf("last%0d", i), last[i], e.last);
                chk($sformatf("ready%0d", i), rdy[i], e.last);
                chk($sformatf("busy%0d", i), busy[i], 1);
            end
        end else begin
            chk($sformatf("gap%0d", i), q[i].size(), 0);
            chk($sformatf("idle_dout%0d", i), dout[i], 0);
            chk($sformatf("idle_first%0d", i), first[i], 0);
            chk($sformatf("idle_last%0d", i), last[i], 0);
            chk($sformatf("idle_ready%0d", i), rdy[i], 1);
            chk($sformatf("idle_busy%0d", i), busy[i], 0);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            mon(0);
            mon(1);
        end
    end

    // Leaves din_valid high; caller drops it when no follow-on word is queued.
    task automatic send(input int i, input logic [7:0] w);
        exp_t e;
        int n;
        din[i] = w;
        dv[i]  = 1'b1;
        n = 0;
        while (!rdy[i] && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 40) begin
            chk($sformatf("ready_timeout%0d", i), 0, 1);
            dv[i] = 1'b0;
        end else begin
            @(posedge clk);
            for (int b = 0; b < 8; b++) begin
                e.b     = (i == 0) ? w[7-b] : w[b];
                e.first = (b == 0);
                e.last  = (b == 7);
                q[i].push_back(e);
            end
            #1;
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((q[0].size() != 0 || q[1].size() != 0) && n < 60) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("drain0", q[0].size(), 0);
        chk("drain1", q[1].size(), 0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        rst    = 1'b1;
        din[0] = 8'hFF;
        din[1] = 8'hFF;
        dv[0]  = 1'b1;
        dv[1]  = 1'b1;
        @(posedge clk);
        #1;
        mon_en = 1;
        @(posedge clk);
        #1;
        rst   = 1'b0;
        dv[0] = 1'b0;
        dv[1] = 1'b0;
        chk("rst_valid", ov[0], 0);
        chk("rst_ready", rdy[0], 1);
        repeat (2) @(posedge clk);
        #1;

        send(0, 8'hA5);
        dv[0] = 1'b0;
        drain();

        send(0, 8'hA5);
        send(0, 8'h3C);
        dv[0] = 1'b0;
        drain();

        send(1, 8'h01);
        dv[1] = 1'b0;
        drain();
        send(1, 8'h80);
        dv[1] = 1'b0;
        drain();

        send(0, 8'hA5);
        dv[0] = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("bp_ready_low", rdy[0], 0);
        send(0, 8'h3C);
        dv[0] = 1'b0;
        drain();

        send(0, 8'hA5);
        dv[0] = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        q[0].delete();
        #1;
        rst = 1'b0;
        chk("rst_mid_valid", ov[0], 0);
        chk("rst_mid_ready", rdy[0], 1);
        send(0, 8'h0F);
        dv[0] = 1'b0;
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
